// File: rtl/sv_uart_rx_packer_if.sv
// Byte/word stream bundle used on both sides of the RX packer.
// The master drives data and valid; the slave answers with ready.
interface sv_uart_rx_packer_if #(
  parameter int DW = 8
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sv_uart_rx_packer.sv
// Packs consecutive UART RX bytes, first byte in the most significant slot,
// into one output word. A partial word is dropped once no byte has arrived
// for itimeout cycles, which keeps word framing aligned after a lost byte.
module sv_uart_rx_packer #(
  parameter int DATA_WIDTH = 24,
  parameter int WORD_WIDTH = 8,
  parameter int TIMER_W    = 16
) (
  input  logic               iclk,
  input  logic               irst,
  sv_uart_rx_packer_if.slave  s_axis,
  sv_uart_rx_packer_if.master m_axis,
  input  logic [TIMER_W-1:0] itimeout,
  output logic               otimeout,
  output logic [15:0]        ofrag_cnt
);

  localparam int WORDS_NUM = DATA_WIDTH / WORD_WIDTH;
  localparam int CNT_W     = (WORDS_NUM > 2) ? $clog2(WORDS_NUM) : 1;
  localparam int HELD_W    = DATA_WIDTH - WORD_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_NUM - 1);

  logic [CNT_W-1:0]      cnt_reg;
  logic [TIMER_W-1:0]    timer_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_valid_reg;
  logic                  timeout_reg;
  logic [15:0]           frag_cnt_reg;

  logic [HELD_W-1:0]     held_word;
  logic [TIMER_W-1:0]    tmo_m1;
  logic                  s_ready;
  logic                  acc;
  logic                  last_byte;
  logic                  stall;
  logic                  expire;

  // Only the final byte of a word can be held off, and only while the
  // output register is occupied and not draining this cycle.
  assign last_byte = (cnt_reg == LAST);
  assign s_ready   = !last_byte || !out_valid_reg || m_axis.tready;
  assign acc       = s_axis.tvalid && s_ready;
  assign stall     = s_axis.tvalid && !s_ready;

  // >= rather than == so a timeout shortened mid-word still fires at once.
  assign tmo_m1 = itimeout - TIMER_W'(1);
  assign expire = (cnt_reg != '0) && (itimeout != '0) && (timer_reg >= tmo_m1) && !acc;

  // One holding register per non-final slot; slot 0 is the MSB byte.
  generate
    for (genvar gi = 0; gi < WORDS_NUM - 1; gi++) begin : g_slot
      logic [WORD_WIDTH-1:0] slot_reg;

      // Capture the incoming byte when it lands in this slot.
      always_ff @(posedge iclk) begin
        if (irst) begin
          slot_reg <= '0;
        end else if (acc && (cnt_reg == CNT_W'(gi))) begin
          slot_reg <= s_axis.tdata;
        end
      end

      assign held_word[HELD_W-1-gi*WORD_WIDTH -: WORD_WIDTH] = slot_reg;
    end
  endgenerate

  // Byte counting, inter-byte timer, output register and discard bookkeeping.
  always_ff @(posedge iclk) begin
    if (irst) begin
      cnt_reg       <= '0;
      timer_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      frag_cnt_reg  <= '0;
    end else begin
      // A drained word frees the register; a word loading on the same edge
      // overrides this below and keeps valid asserted.
      if (out_valid_reg && m_axis.tready) begin
        out_valid_reg <= 1'b0;
      end

      if (acc) begin
        timer_reg <= '0;
        if (last_byte) begin
          out_data_reg  <= {held_word, s_axis.tdata};
          out_valid_reg <= 1'b1;
          cnt_reg       <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else if (expire) begin
        cnt_reg   <= '0;
        timer_reg <= '0;
      end else if (cnt_reg == '0) begin
        timer_reg <= '0;
      end else if (!stall) begin
        // A stalled final byte is already on the bus, so time stops.
        timer_reg <= timer_reg + TIMER_W'(1);
      end

      timeout_reg <= expire;
      if (expire && (frag_cnt_reg != 16'hFFFF)) begin
        frag_cnt_reg <= frag_cnt_reg + 16'd1;
      end
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = out_data_reg;
  assign m_axis.tvalid = out_valid_reg;
  assign otimeout      = timeout_reg;
  assign ofrag_cnt     = frag_cnt_reg;

endmodule

// File: tb/tb_sv_uart_rx_packer.sv
// Self-checking bench for sv_uart_rx_packer (24-bit words): directed scenarios
// followed by randomized traffic, all compared against a queue-based model of
// the byte-packing, back-pressure and timeout rules.
module tb_sv_uart_rx_packer;

  localparam int DW = 24;
  localparam int WN = DW / 8;
  localparam int TW = 16;

  logic          iclk = 1'b0;
  logic          irst = 1'b1;
  logic [TW-1:0] itimeout = '0;
  logic          otimeout;
  logic [15:0]   ofrag_cnt;

  sv_uart_rx_packer_if #(.DW(8))  s_if ();
  sv_uart_rx_packer_if #(.DW(DW)) m_if ();

  sv_uart_rx_packer #(
    .DATA_WIDTH(DW),
    .WORD_WIDTH(8),
    .TIMER_W   (TW)
  ) dut (
    .iclk     (iclk),
    .irst     (irst),
    .s_axis   (s_if.slave),
    .m_axis   (m_if.master),
    .itimeout (itimeout),
    .otimeout (otimeout),
    .ofrag_cnt(ofrag_cnt)
  );

  always #5 iclk = ~iclk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes waiting for a word, cycles since the last accepted
  // byte, the pending output word, and the discard indicators.
  logic [7:0]    held[$];
  int            since;
  bit            mv;
  logic [DW-1:0] mw;
  bit            mto;
  int            mfrag;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    held.delete();
    since = 0;
    mv    = 0;
    mw    = '0;
    mto   = 0;
    mfrag = 0;
  endtask

  // One clock cycle: drive inputs, check DUT against the model mid-cycle,
  // then advance the model across the coming edge.
  task automatic step(input bit v, input logic [7:0] d, input bit mr, output bit acc);
    bit            exp_ready;
    bit            load;
    logic [DW-1:0] w;
    s_if.tvalid = v;
    s_if.tdata  = d;
    m_if.tready = mr;
    @(negedge iclk);
    exp_ready = !((held.size() == WN - 1) && mv && !mr);
    chk("s_tready", 32'(s_if.tready), 32'(exp_ready));
    chk("m_tvalid", 32'(m_if.tvalid), 32'(mv));
    chk("m_tdata",  32'(m_if.tdata),  32'(mw));
    chk("otimeout", 32'(otimeout),    32'(mto));
    chk("frag_cnt", 32'(ofrag_cnt),   32'(mfrag));
    if (mv && mr) $display("word %h delivered t=%0t", mw, $time);
    acc  = v && exp_ready;
    load = 0;
    mto  = 0;
    if (acc) begin
      held.push_back(d);
      since = 0;
      if (held.size() == WN) begin
        w = '0;
        foreach (held[i]) w = {w[DW-9:0], held[i]};
        mw   = w;
        load = 1;
        held.delete();
      end
    end else if (held.size() != 0) begin
      if ((itimeout != 0) && (since + 1 >= int'(itimeout))) begin
        held.delete();
        since = 0;
        mto   = 1;
        if (mfrag != 16'hFFFF) mfrag++;
      end else if (!v) begin
        since++;
      end
    end
    if (load) mv = 1;
    else if (mv && mr) mv = 0;
    @(posedge iclk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit mr);
    bit a;
    step(1'b1, d, mr, a);
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL send_refused got=0 exp=1 byte=%h", d);
    end
  endtask

  task automatic idle(input int n, input bit mr);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, mr, a);
  endtask

  task automatic do_reset();
    irst        = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    @(posedge iclk);
    #1;
    @(negedge iclk);
    chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_m_tdata",  32'(m_if.tdata),  32'd0);
    chk("rst_otimeout", 32'(otimeout),    32'd0);
    chk("rst_frag_cnt", 32'(ofrag_cnt),   32'd0);
    chk("rst_s_tready", 32'(s_if.tready), 32'd1);
    @(posedge iclk);
    #1;
    irst = 1'b0;
    model_clear();
  endtask

  initial begin
    bit a;
    int pick;
    model_clear();
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;

    do_reset();

    // Back-to-back word, timeout disabled; valid one cycle after last accept.
    itimeout = '0;
    send(8'hA1, 1'b1);
    send(8'hB2, 1'b1);
    send(8'hC3, 1'b1);
    chk("word_a1b2c3", 32'(m_if.tdata),  32'h00A1B2C3);
    chk("word_valid",  32'(m_if.tvalid), 32'd1);
    idle(3, 1'b1);

    // Back-pressure: first word held, final byte of second word stalled.
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    chk("held_010203", 32'(m_if.tdata), 32'h00010203);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h06, 1'b0, a);
    chk("stalled_06", 32'(a), 32'd0);
    send(8'h06, 1'b1);
    chk("word_040506", 32'(m_if.tdata), 32'h00040506);
    idle(2, 1'b1);

    // Timeout discards a partial word after exactly 10 idle cycles.
    itimeout = 16'd10;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    idle(10, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    send(8'h55, 1'b1);
    chk("word_334455", 32'(m_if.tdata), 32'h00334455);
    chk("frag_one",    32'(ofrag_cnt),  32'd1);

    // Bytes 9 cycles apart, then a byte landing on the would-be expiry edge.
    send(8'h61, 1'b1);
    idle(8, 1'b1);
    send(8'h62, 1'b1);
    idle(9, 1'b1);
    send(8'h63, 1'b1);
    chk("word_spaced", 32'(m_if.tdata), 32'h00616263);
    chk("frag_still",  32'(ofrag_cnt),  32'd1);
    idle(2, 1'b1);

    // Reset mid-word drops the partial bytes.
    send(8'hE1, 1'b1);
    send(8'hE2, 1'b1);
    do_reset();
    send(8'h77, 1'b1);
    send(8'h88, 1'b1);
    send(8'h99, 1'b1);
    chk("word_778899", 32'(m_if.tdata), 32'h00778899);
    idle(2, 1'b1);

    // Saturation: preload the discard counter near full, then overflow it.
    @(negedge iclk);
    force dut.frag_cnt_reg = 16'hFFFC;
    @(posedge iclk);
    #1;
    release dut.frag_cnt_reg;
    mfrag    = 16'hFFFC;
    itimeout = 16'd1;
    for (int i = 0; i < 6; i++) begin
      send(8'(8'hF0 + i), 1'b1);
      idle(1, 1'b1);
    end
    idle(1, 1'b1);
    chk("frag_sat", 32'(ofrag_cnt), 32'h0000FFFF);

    // Randomized traffic with occasional timeout changes, including mid-word.
    itimeout = 16'd4;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        pick = $urandom_range(0, 3);
        itimeout = (pick == 0) ? 16'd0 : (pick == 1) ? 16'd2 :
                   (pick == 2) ? 16'd5 : 16'd12;
      end
      step($urandom_range(0, 99) < 50, 8'($urandom), $urandom_range(0, 99) < 65, a);
    end
    idle(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
